uart_frame_ctrl: RTL and testbench

UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

---
 rtl/uart_frame_ctrl_if.sv | 23 ++
 rtl/uart_frame_ctrl.sv | 151 +++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_ctrl_if.sv
// Byte-stream input and register-file write bus of the UART frame controller.
// The receiver side drives pi_*; the controller drives the write port and the status flags.
interface uart_frame_ctrl_if;
   logic [7:0] pi_data;
   logic       pi_flag;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       busy;

   modport master (
      output pi_data, pi_flag,
      input  wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy
   );

   modport slave (
      input  pi_data, pi_flag,
      output wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy
   );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Parses HEADER/ADDR/LEN/PAYLOAD/CSUM frames from a UART byte stream and replays
// verified payloads as consecutive register-file writes starting at the frame's base address.
module uart_frame_ctrl #(
   parameter logic [7:0]  HEADER      = 8'hAA,
   parameter int unsigned MAX_LEN     = 8,
   parameter int unsigned TIMEOUT_CYC = 52080
) (
   input logic              system_clk,
   input logic              system_rst,
   uart_frame_ctrl_if.slave bus
);

   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int CW = $clog2(MAX_LEN + 1);
   localparam int GW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [GW-1:0] GAP_LAST  = GW'(TIMEOUT_CYC - 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ADDR    = 3'd1;
   localparam logic [2:0] LEN     = 3'd2;
   localparam logic [2:0] PAYLOAD = 3'd3;
   localparam logic [2:0] CSUM    = 3'd4;
   localparam logic [2:0] WRITE   = 3'd5;

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [7:0]    csum;
   logic [7:0]    base;
   logic [CW-1:0] len;
   logic [CW-1:0] idx;
   logic [GW-1:0] gap;
   logic [7:0]    buffer [0:(1<<IW)-1];

   logic counting;
   logic expired;
   logic len_ok;
   logic last_pl;
   logic write_done;

   // A byte arriving in the expiry cycle wins over the timeout.
   always_comb begin
      counting   = (state == ADDR) || (state == LEN) || (state == PAYLOAD) || (state == CSUM);
      expired    = counting && !bus.pi_flag && (gap == GAP_LAST);
      len_ok     = (bus.pi_data != 8'd0) && (bus.pi_data <= MAX_LEN_B);
      last_pl    = (idx == (len - CW'(1)));
      write_done = (idx == len);
      state_nxt  = state;
      case (state)
         IDLE:    if (bus.pi_flag && bus.pi_data == HEADER) state_nxt = ADDR;
         ADDR:    if (bus.pi_flag) state_nxt = LEN;
                  else if (expired) state_nxt = IDLE;
         LEN:     if (bus.pi_flag) state_nxt = len_ok ? PAYLOAD : IDLE;
                  else if (expired) state_nxt = IDLE;
         PAYLOAD: if (bus.pi_flag && last_pl) state_nxt = CSUM;
                  else if (expired) state_nxt = IDLE;
         CSUM:    if (bus.pi_flag) state_nxt = (bus.pi_data == csum) ? WRITE : IDLE;
                  else if (expired) state_nxt = IDLE;
         WRITE:   if (write_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge system_clk or posedge system_rst) begin
      if (system_rst) begin
         state         <= IDLE;
         bus.busy      <= 1'b0;
         bus.wr_en     <= 1'b0;
         bus.wr_addr   <= 8'h00;
         bus.wr_data   <= 8'h00;
         bus.frame_ok  <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.err_code  <= 2'd0;
         csum          <= 8'h00;
         base          <= 8'h00;
         len           <= '0;
         idx           <= '0;
         gap           <= '0;
      end else begin
         state         <= state_nxt;
         bus.busy      <= (state_nxt != IDLE);
         bus.wr_en     <= 1'b0;
         bus.frame_ok  <= 1'b0;
         bus.frame_err <= 1'b0;

         if (bus.pi_flag || !counting || expired) gap <= '0;
         else                                     gap <= gap + GW'(1);

         if (expired) begin
            bus.frame_err <= 1'b1;
            bus.err_code  <= 2'd3;
         end

         case (state)
            IDLE: begin
               csum <= 8'h00;
               idx  <= '0;
            end
            ADDR: if (bus.pi_flag) begin
               base <= bus.pi_data;
               csum <= bus.pi_data;
            end
            LEN: if (bus.pi_flag) begin
               if (len_ok) begin
                  len  <= bus.pi_data[CW-1:0];
                  csum <= csum + bus.pi_data;
                  idx  <= '0;
               end else begin
                  bus.frame_err <= 1'b1;
                  bus.err_code  <= 2'd2;
               end
            end
            PAYLOAD: if (bus.pi_flag) begin
               csum <= csum + bus.pi_data;
               idx  <= last_pl ? '0 : idx + CW'(1);
            end
            // A matching checksum launches the first write immediately.
            CSUM: if (bus.pi_flag) begin
               if (bus.pi_data == csum) begin
                  bus.wr_en   <= 1'b1;
                  bus.wr_addr <= base;
                  bus.wr_data <= buffer[0];
                  idx         <= CW'(1);
               end else begin
                  bus.frame_err <= 1'b1;
                  bus.err_code  <= 2'd1;
               end
            end
            WRITE: begin
               if (!write_done) begin
                  bus.wr_en   <= 1'b1;
                  bus.wr_addr <= base + 8'(idx);
                  bus.wr_data <= buffer[idx[IW-1:0]];
                  idx         <= idx + CW'(1);
               end else begin
                  bus.frame_ok <= 1'b1;
                  idx          <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Payload storage needs no reset; a frame only reads the slots it has just written.
   always_ff @(posedge system_clk) begin
      if (state == PAYLOAD && bus.pi_flag)
         buffer[idx[IW-1:0]] <= bus.pi_data;
   end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed and random frames against a
// frame-level reference model, plus timeout, WRITE-drop and reset-abort scenarios.
module tb_uart_frame_ctrl;

   localparam int         MAX_LEN = 8;
   localparam int         TO      = 60;
   localparam logic [7:0] HEADER  = 8'hAA;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_frame_ctrl_if bus ();

   uart_frame_ctrl #(
      .HEADER     (HEADER),
      .MAX_LEN    (MAX_LEN),
      .TIMEOUT_CYC(TO)
   ) dut (
      .system_clk(clk),
      .system_rst(rst),
      .bus       (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   logic [15:0] wr_q [$];
   int          ok_cnt;
   int          err_cnt;
   logic [1:0]  last_code;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.wr_en) wr_q.push_back({bus.wr_addr, bus.wr_data});
         if (bus.frame_ok) ok_cnt++;
         if (bus.frame_err) begin
            err_cnt++;
            last_code = bus.err_code;
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      wr_q.delete();
      ok_cnt    = 0;
      err_cnt   = 0;
      last_code = 2'd0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bus.pi_data = b;
      bus.pi_flag = 1'b1;
      tick();
      bus.pi_flag = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.pi_flag = 1'b0;
      bus.pi_data = 8'h00;
      repeat (3) tick();
      n_cmp++;
      if ({bus.wr_en, bus.frame_ok, bus.frame_err, bus.busy} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL reset_flags: got %b expected 0000",
                  {bus.wr_en, bus.frame_ok, bus.frame_err, bus.busy});
      end
      n_cmp++;
      if ({bus.wr_addr, bus.wr_data, bus.err_code} !== 18'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_bus: got %h expected 0",
                  {bus.wr_addr, bus.wr_data, bus.err_code});
      end
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_frames();
      logic [7:0]  addr, len, cs;
      logic [7:0]  pl [16];
      logic [15:0] exp_q [$];
      int          code, s, mode, g;
      logic [7:0]  nb;
      for (int k = 0; k < 18; k++) begin
         for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
         case (k)
            0: begin addr = 8'h10; len = 8'd3; pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; cs = 8'h79; end
            1: begin addr = 8'h10; len = 8'd3; pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; cs = 8'h78; end
            2: begin addr = 8'h10; len = 8'd0; cs = 8'h00; end
            3: begin addr = 8'h10; len = 8'd9; cs = 8'h00; end
            4: begin addr = 8'hFF; len = 8'd2; pl[0] = 8'h01; pl[1] = 8'h02; cs = 8'h04; end
            5: begin addr = 8'hAA; len = 8'd2; pl[0] = 8'hAA; pl[1] = 8'hAA; cs = 8'h00; end
            default: begin
               addr = 8'($urandom);
               len  = 8'($urandom_range(1, MAX_LEN));
               s    = addr + len;
               for (int i = 0; i < len; i++) s += pl[i];
               cs   = 8'(s);
               mode = $urandom_range(0, 99);
               if (mode < 15)
                  len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
               else if (mode < 35)
                  cs = cs + 8'($urandom_range(1, 255));
            end
         endcase

         exp_q.delete();
         if (len == 0 || len > MAX_LEN) code = 2;
         else begin
            s = addr + len;
            for (int i = 0; i < len; i++) s += pl[i];
            if ((s % 256) != cs) code = 1;
            else begin
               code = 0;
               for (int i = 0; i < len; i++) exp_q.push_back({8'((addr + i) % 256), pl[i]});
            end
         end

         clear_mon();
         for (int j = 0; j < $urandom_range(0, 2); j++) begin
            nb = 8'($urandom);
            if (nb == HEADER) nb = nb ^ 8'h01;
            send_byte(nb, $urandom_range(0, 3));
         end
         g = $urandom_range(0, 3);
         send_byte(HEADER, g);
         send_byte(addr, $urandom_range(0, 3));
         send_byte(len, $urandom_range(0, 3));
         if (code != 2) begin
            for (int i = 0; i < len; i++) send_byte(pl[i], $urandom_range(0, 3));
            send_byte(cs, 0);
         end
         repeat (MAX_LEN + 8) tick();

         n_cmp++;
         if (wr_q.size() != exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL frame%0d_wr_count: got %0d expected %0d", k, wr_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            n_cmp++;
            if (wr_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("[TB] FAIL frame%0d_write%0d: got %h expected %h", k, i, wr_q[i], exp_q[i]);
            end
         end
         n_cmp++;
         if (ok_cnt != ((code == 0) ? 1 : 0)) begin
            n_fail++;
            $display("[TB] FAIL frame%0d_ok_count: got %0d expected %0d", k, ok_cnt, (code == 0) ? 1 : 0);
         end
         n_cmp++;
         if (err_cnt != ((code != 0) ? 1 : 0)) begin
            n_fail++;
            $display("[TB] FAIL frame%0d_err_count: got %0d expected %0d", k, err_cnt, (code != 0) ? 1 : 0);
         end
         if (code != 0) begin
            n_cmp++;
            if (last_code !== 2'(code)) begin
               n_fail++;
               $display("[TB] FAIL frame%0d_err_code: got %0d expected %0d", k, last_code, code);
            end
         end
         n_cmp++;
         if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL frame%0d_busy: got %b expected 0", k, bus.busy);
         end
      end
   endtask

   task automatic test_timeout();
      int n;
      clear_mon();
      send_byte(HEADER, 0);
      send_byte(8'h10, 0);
      send_byte(8'h02, 0);
      send_byte(8'h55, 0);
      n = 0;
      while (bus.frame_err !== 1'b1 && n < TO + 20) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n != TO) begin
         n_fail++;
         $display("[TB] FAIL timeout_latency: got %0d cycles expected %0d", n, TO);
      end
      n_cmp++;
      if (bus.err_code !== 2'd3) begin
         n_fail++;
         $display("[TB] FAIL timeout_code: got %0d expected 3", bus.err_code);
      end
      n_cmp++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL timeout_busy: got %b expected 0", bus.busy);
      end
      tick();
      clear_mon();
      send_byte(HEADER, 1);
      send_byte(8'h20, 1);
      send_byte(8'h01, 1);
      send_byte(8'h5A, 1);
      send_byte(8'h7B, 0);
      repeat (6) tick();
      n_cmp++;
      if (wr_q.size() != 1 || wr_q[0] !== 16'h205A || ok_cnt != 1) begin
         n_fail++;
         $display("[TB] FAIL after_timeout_frame: got n=%0d ok=%0d expected n=1 (20,5A) ok=1",
                  wr_q.size(), ok_cnt);
      end
   endtask

   task automatic test_timeout_boundary();
      clear_mon();
      send_byte(HEADER, 0);
      send_byte(8'h30, 0);
      send_byte(8'h02, TO - 1);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'h35, 0);
      repeat (6) tick();
      n_cmp++;
      if (err_cnt != 0 || ok_cnt != 1 || wr_q.size() != 2) begin
         n_fail++;
         $display("[TB] FAIL timeout_boundary: got err=%0d ok=%0d writes=%0d expected 0/1/2",
                  err_cnt, ok_cnt, wr_q.size());
      end
   endtask

   task automatic test_write_drop();
      clear_mon();
      send_byte(HEADER, 0);
      send_byte(8'h10, 0);
      send_byte(8'h03, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h79, 0);
      n_cmp++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 8'h10, 8'h11}) begin
         n_fail++;
         $display("[TB] FAIL first_write: got %h expected 11011", {bus.wr_en, bus.wr_addr, bus.wr_data});
      end
      send_byte(HEADER, 0);
      n_cmp++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 8'h11, 8'h22}) begin
         n_fail++;
         $display("[TB] FAIL second_write: got %h expected 11122", {bus.wr_en, bus.wr_addr, bus.wr_data});
      end
      tick();
      tick();
      n_cmp++;
      if ({bus.frame_ok, bus.wr_en} !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL ok_after_last_write: got %b expected 10", {bus.frame_ok, bus.wr_en});
      end
      repeat (3) tick();
      n_cmp++;
      if (bus.busy !== 1'b0 || wr_q.size() != 3) begin
         n_fail++;
         $display("[TB] FAIL write_drop: got busy=%b writes=%0d expected busy=0 writes=3",
                  bus.busy, wr_q.size());
      end
   endtask

   task automatic test_reset_mid_write();
      clear_mon();
      send_byte(HEADER, 0);
      send_byte(8'h10, 0);
      send_byte(8'h03, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h79, 0);
      tick();
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.wr_en, bus.frame_ok, bus.frame_err, bus.busy, bus.wr_addr, bus.wr_data, bus.err_code} !== 22'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_mid_write: got %h expected 0",
                  {bus.wr_en, bus.frame_ok, bus.frame_err, bus.busy, bus.wr_addr, bus.wr_data, bus.err_code});
      end
      tick();
      tick();
      rst = 1'b0;
      repeat (8) tick();
      n_cmp++;
      if (ok_cnt != 0 || wr_q.size() != 1 || bus.wr_en !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL abort_after_reset: got ok=%0d writes=%0d expected ok=0 writes=1",
                  ok_cnt, wr_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_frames();
      test_timeout();
      test_timeout_boundary();
      test_write_drop();
      test_reset_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
